// File: rtl/uart_rx_core_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling and vote-tick constants.
// Intended for reuse by the transmit side as well.
package uart_rx_core_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StStart = 3'd1,
        StData  = 3'd2,
        StStop  = 3'd3,
        StBreak = 3'd4
    } state_e;

    localparam int unsigned Oversample = 16;

    localparam logic [3:0] VoteTickA = 4'd7;
    localparam logic [3:0] VoteTickB = 4'd8;
    localparam logic [3:0] VoteTickC = 4'd9;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// Receive-side consumer interface: FIFO head with valid/ready, occupancy and error pulses.
interface uart_rx_core_if #(
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned CountW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [CountW-1:0] fifo_count;
    logic              frame_err;
    logic              overrun;

    modport master (
        output rx_data, rx_valid, fifo_count, frame_err, overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, fifo_count, frame_err, overrun,
        output rx_ready
    );

endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO; DEPTH must be a power of two so pointers wrap naturally.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [7:0]             din_i,
    input  logic                   pop_i,
    output logic [7:0]             dout_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;
    assign dout_o  = empty_o ? 8'h00 : mem_q[rptr_q];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = wptr_q + AW'(1);
        if (do_pop)  rptr_d = rptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 16x oversampling, 3-sample majority vote per bit, FWFT receive FIFO,
// one-cycle frame_err/overrun pulses.
module uart_rx_core
    import uart_rx_core_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 40000000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rx_i,
    uart_rx_core_if.master bus
);
    localparam int unsigned DIV    = CLK_FREQ / (BAUD * Oversample);
    localparam int unsigned DivW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned CountW = $clog2(FIFO_DEPTH) + 1;

    logic            rx_meta_q, rx_sync_q;
    state_e          state_q, state_d;
    logic [DivW-1:0] div_q, div_d;
    logic [3:0]      tick_q, tick_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            vote_a_q, vote_a_d, vote_b_q, vote_b_d;
    logic            frame_err_q, frame_err_d, overrun_q, overrun_d;
    logic            strobe, decide, vote, push, pop;
    logic            fifo_empty, fifo_full;
    logic [7:0]      fifo_dout;
    logic [CountW-1:0] fifo_count;

    assign strobe = (div_q == '0);
    assign decide = strobe && (tick_q == VoteTickC);
    assign vote   = majority3(vote_a_q, vote_b_q, rx_sync_q);
    assign pop    = !fifo_empty && bus.rx_ready;

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        tick_d      = tick_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        vote_a_d    = vote_a_q;
        vote_b_d    = vote_b_q;
        push        = 1'b0;
        frame_err_d = 1'b0;

        if (state_q == StStart || state_q == StData || state_q == StStop) begin
            if (div_q == DivW'(DIV - 1)) begin
                div_d  = '0;
                tick_d = tick_q + 4'd1;
            end else begin
                div_d = div_q + DivW'(1);
            end
            if (strobe && tick_q == VoteTickA) vote_a_d = rx_sync_q;
            if (strobe && tick_q == VoteTickB) vote_b_d = rx_sync_q;
        end

        case (state_q)
            StIdle: begin
                // Divider restarts here so tick 0 lines up with the detected start edge.
                div_d  = '0;
                tick_d = '0;
                if (!rx_sync_q) state_d = StStart;
            end
            StStart: begin
                if (decide) begin
                    if (!vote) begin
                        state_d = StData;
                        bit_d   = 3'd0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StData: begin
                if (decide) begin
                    shift_d = {vote, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = StStop;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            StStop: begin
                if (decide) begin
                    if (vote) begin
                        push    = 1'b1;
                        state_d = StIdle;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StBreak;
                    end
                end
            end
            StBreak: begin
                if (rx_sync_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        overrun_d = push && fifo_full && !pop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            state_q     <= StIdle;
            div_q       <= '0;
            tick_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            vote_a_q    <= 1'b1;
            vote_b_q    <= 1'b1;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_meta_q   <= rx_i;
            rx_sync_q   <= rx_meta_q;
            state_q     <= state_d;
            div_q       <= div_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            vote_a_q    <= vote_a_d;
            vote_b_q    <= vote_b_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (shift_q),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    assign bus.rx_data    = fifo_dout;
    assign bus.rx_valid   = !fifo_empty;
    assign bus.fifo_count = fifo_count;
    assign bus.frame_err  = frame_err_q;
    assign bus.overrun    = overrun_q;

endmodule
